sample_frame_ctrl: RTL and testbench

SAMPLE_FRAME_CTRL -- requirements
Module: sample_frame_ctrl

---
 rtl/sample_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sample_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_ctrl.sv
// rtl/sample_frame_ctrl.sv - UART sample framer: sync hunt, 4-byte merge sequencing, single-entry sample slot.
// Optional trailing XOR checksum byte enabled by defining FRAME_CHECKSUM_EN.
module sample_frame_ctrl #(
  parameter int WIDTH       = 16,
  parameter int FRAME_LEN   = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_valid_i,
  input  logic [7:0]         uart_data_i,
  output logic               merge_start_o,
  output logic               merge_rst_o,
  input  logic               merge_finished_i,
  input  logic [2*WIDTH-1:0] merge_data_i,
  output logic [WIDTH-1:0]   sample_i_o,
  output logic [WIDTH-1:0]   sample_q_o,
  output logic               sample_valid_o,
  input  logic               sample_ready_i,
  output logic               frame_err_o,
  output logic               overflow_o
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    HUNT, SYNC1, COLLECT, CAPTURE
`ifdef FRAME_CHECKSUM_EN
    , TAIL
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         sample_cnt_q, sample_cnt_d;
  logic [IW-1:0]      idle_q;
  logic [2*WIDTH-1:0] slot_q;
  logic               slot_valid_q;
  logic               overflow_q;
  logic               capture, start, mrst, err, timeout;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  // Fires on the TIMEOUT_CYC-th consecutive cycle without a byte.
  assign timeout = (idle_q == IW'(TIMEOUT_CYC - 1)) && !uart_valid_i;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    sample_cnt_d = sample_cnt_q;
    capture      = 1'b0;
    start        = 1'b0;
    mrst         = 1'b0;
    err          = 1'b0;
    case (state_q)
      HUNT: begin
        if (uart_valid_i && uart_data_i == 8'hA5) state_d = SYNC1;
      end
      SYNC1: begin
        if (timeout) begin
          err     = 1'b1;
          mrst    = 1'b1;
          state_d = HUNT;
        end else if (uart_valid_i) begin
          if (uart_data_i == 8'h5A) begin
            state_d      = COLLECT;
            byte_cnt_d   = 2'd0;
            sample_cnt_d = 8'd0;
            mrst         = 1'b1;
          end else if (uart_data_i != 8'hA5) begin
            state_d = HUNT;
          end
        end
      end
      COLLECT: begin
        if (timeout) begin
          err     = 1'b1;
          mrst    = 1'b1;
          state_d = HUNT;
        end else if (uart_valid_i) begin
          start = 1'b1;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = CAPTURE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      CAPTURE: begin
        // A byte landing here cannot be forwarded, so the frame is abandoned.
        if (uart_valid_i) begin
          err     = 1'b1;
          state_d = HUNT;
        end else if (!merge_finished_i) begin
          err     = 1'b1;
          mrst    = 1'b1;
          state_d = HUNT;
        end else begin
          capture      = 1'b1;
          sample_cnt_d = sample_cnt_q + 8'd1;
          if (sample_cnt_q == 8'(FRAME_LEN - 1)) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = TAIL;
`else
            state_d = HUNT;
`endif
          end else begin
            state_d = COLLECT;
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      TAIL: begin
        if (timeout) begin
          err     = 1'b1;
          mrst    = 1'b1;
          state_d = HUNT;
        end else if (uart_valid_i) begin
          err     = (uart_data_i != csum_q);
          state_d = HUNT;
        end
      end
`endif
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      byte_cnt_q   <= 2'd0;
      sample_cnt_q <= 8'd0;
      idle_q       <= '0;
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      if (uart_valid_i) idle_q <= '0;
      else if (idle_q < IW'(TIMEOUT_CYC)) idle_q <= idle_q + 1'b1;
      // Same-edge capture and handshake keeps the new sample resident.
      if (capture) begin
        if (!slot_valid_q || sample_ready_i) begin
          slot_q       <= merge_data_i;
          slot_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (slot_valid_q && sample_ready_i) begin
        slot_valid_q <= 1'b0;
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) csum_q <= 8'd0;
    else if (state_q == SYNC1) csum_q <= 8'd0;
    else if (start) csum_q <= csum_q ^ uart_data_i;
  end
`endif

  // Strobes are gated so nothing leaks out while reset is held.
  assign merge_start_o  = start & rst_n;
  assign merge_rst_o    = mrst & rst_n;
  assign frame_err_o    = err & rst_n;
  assign sample_i_o     = slot_q[2*WIDTH-1:WIDTH];
  assign sample_q_o     = slot_q[WIDTH-1:0];
  assign sample_valid_o = slot_valid_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// tb/tb_sample_frame_ctrl.sv - self-checking bench for sample_frame_ctrl with a behavioural merge block and frame scoreboard.
module tb_sample_frame_ctrl;

  localparam int WIDTH = 16;
  localparam int FLEN  = 2;
  localparam int TOUT  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              uart_valid_i = 1'b0;
  logic [7:0]        uart_data_i = 8'd0;
  logic              merge_start_o, merge_rst_o;
  logic              merge_finished_i;
  logic [2*WIDTH-1:0] merge_data_i;
  logic [WIDTH-1:0]  sample_i_o, sample_q_o;
  logic              sample_valid_o;
  logic              sample_ready_i = 1'b1;
  logic              frame_err_o, overflow_o;

  sample_frame_ctrl #(.WIDTH(WIDTH), .FRAME_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .uart_valid_i(uart_valid_i), .uart_data_i(uart_data_i),
    .merge_start_o(merge_start_o), .merge_rst_o(merge_rst_o),
    .merge_finished_i(merge_finished_i), .merge_data_i(merge_data_i),
    .sample_i_o(sample_i_o), .sample_q_o(sample_q_o), .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i), .frame_err_o(frame_err_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment model of the 4-byte merge block.
  logic [31:0] mbuf;
  int          mcnt;
  logic        break_merge = 1'b0;
  always @(posedge clk) begin
    if (!rst_n || merge_rst_o) begin
      mbuf <= 32'd0;
      mcnt <= 0;
    end else if (merge_start_o) begin
      mbuf <= {mbuf[23:0], uart_data_i};
      mcnt <= (mcnt == 4) ? 1 : mcnt + 1;
    end
  end
  assign merge_finished_i = (mcnt == 4) && !break_merge;
  assign merge_data_i     = mbuf;

  int          act_start = 0, act_rst = 0, act_err = 0;
  logic [31:0] got_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (merge_start_o) act_start++;
      if (merge_rst_o)   act_rst++;
      if (frame_err_o)   act_err++;
      if (sample_valid_o && sample_ready_i) got_q.push_back({sample_i_o, sample_q_o});
    end
  end

  int          exp_start = 0, exp_rst = 0, exp_err = 0;
  logic [31:0] exp_q[$];
  int          base_start = 0, base_rst = 0, base_err = 0, base_got = 0;
  logic [7:0]  pl_q[$];

  task automatic resync();
    base_start = act_start;
    base_rst   = act_rst;
    base_err   = act_err;
    base_got   = got_q.size();
    exp_start  = 0;
    exp_rst    = 0;
    exp_err    = 0;
    exp_q.delete();
  endtask

  task automatic verify(input string tag);
    check({tag, ".starts"}, act_start - base_start, exp_start);
    check({tag, ".rsts"}, act_rst - base_rst, exp_rst);
    check({tag, ".errs"}, act_err - base_err, exp_err);
    check({tag, ".nsamp"}, got_q.size() - base_got, exp_q.size());
    foreach (exp_q[i])
      if (base_got + i < got_q.size())
        check($sformatf("%s.samp%0d", tag, i), got_q[base_got + i], exp_q[i]);
    resync();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".start"}, merge_start_o, 0);
    check({tag, ".mrst"}, merge_rst_o, 0);
    check({tag, ".si"}, sample_i_o, 0);
    check({tag, ".sq"}, sample_q_o, 0);
    check({tag, ".valid"}, sample_valid_o, 0);
    check({tag, ".err"}, frame_err_o, 0);
    check({tag, ".ovf"}, overflow_o, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    uart_valid_i = 1'b1;
    uart_data_i  = b;
    @(posedge clk); #1;
    uart_valid_i = 1'b0;
  endtask

  task automatic rand_payload();
    pl_q.delete();
    for (int i = 0; i < 4 * FLEN; i++) pl_q.push_back(8'($urandom_range(255)));
  endtask

  // Sends a complete frame from pl_q and books its expected effects.
  task automatic send_frame(input int maxgap, input bit bad_cs);
    logic [7:0] cs;
    cs = 8'd0;
    send_byte(8'hA5);
    send_byte(8'h5A);
    exp_rst++;
    foreach (pl_q[i]) begin
      send_byte(pl_q[i]);
      cs = cs ^ pl_q[i];
      exp_start++;
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(posedge clk);
    end
    for (int s = 0; s < FLEN; s++)
      exp_q.push_back({pl_q[4*s], pl_q[4*s+1], pl_q[4*s+2], pl_q[4*s+3]});
`ifdef FRAME_CHECKSUM_EN
    send_byte(bad_cs ? (cs ^ 8'h01) : cs);
    if (bad_cs) exp_err++;
`else
    if (bad_cs) exp_err += 0;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);
    resync();

    pl_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_frame(0, 1'b0);
    idle(4);
    check("basic.first_word", exp_q[0], 32'h12345678);
    verify("basic");

    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h5A);
    exp_rst++;
    rand_payload();
    for (int i = 0; i < 4; i++) send_byte(pl_q[i]);
    exp_start += 4;
    exp_q.push_back({pl_q[0], pl_q[1], pl_q[2], pl_q[3]});
    idle(20);
    exp_err++;
    exp_rst++;
    verify("hunt");

    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h11);
    send_byte(8'h22);
    exp_rst++;
    exp_start += 2;
    idle(TOUT - 1);
    check("tmo.early", act_err - base_err, 0);
    idle(1);
    check("tmo.fire", act_err - base_err, 1);
    exp_err++;
    exp_rst++;
    verify("tmo");

    sample_ready_i = 1'b0;
    rand_payload();
    send_frame(0, 1'b0);
    idle(4);
    check("ovf.valid", sample_valid_o, 1);
    check("ovf.held", {sample_i_o, sample_q_o}, exp_q[0]);
    check("ovf.flag", overflow_o, 1);
    void'(exp_q.pop_back());
    sample_ready_i = 1'b1;
    idle(3);
    check("ovf.drained", sample_valid_o, 0);
    verify("ovf");

    rand_payload();
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 3; i++) send_byte(pl_q[i]);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    check_zero("midrst");
    rst_n = 1'b1;
    idle(1);
    resync();
    rand_payload();
    send_frame(2, 1'b0);
    idle(4);
    verify("post_rst");

    break_merge = 1'b1;
    rand_payload();
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_byte(pl_q[i]);
    exp_rst += 2;
    exp_start += 4;
    exp_err++;
    idle(4);
    break_merge = 1'b0;
    verify("mismatch");

    rand_payload();
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 3; i++) send_byte(pl_q[i]);
    @(posedge clk); #1;
    uart_valid_i = 1'b1;
    uart_data_i  = pl_q[3];
    @(posedge clk); #1;
    uart_data_i  = 8'h33;
    @(posedge clk); #1;
    uart_valid_i = 1'b0;
    exp_rst++;
    exp_start += 4;
    exp_err++;
    idle(4);
    verify("lost");

    for (int f = 0; f < 25; f++) begin
      int njunk;
      logic [7:0] j;
      bit bad;
      njunk = $urandom_range(3);
      for (int k = 0; k < njunk; k++) begin
        j = 8'($urandom_range(255));
        if (j == 8'hA5) j = 8'h00;
        send_byte(j);
      end
      if ($urandom_range(3) == 0) begin
        send_byte(8'hA5);
        send_byte(8'h11);
      end
      bad = ($urandom_range(3) == 0);
      rand_payload();
      send_frame(3, bad);
      idle(4);
      verify($sformatf("rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
